// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC back-end blocks.
// The delta regression reciprocal is derived at elaboration from the window half-width.
package mfcc_pkg;
  localparam int MFCC_DATA_WIDTH = 16;
  localparam int DELTA_ACC_WIDTH = 20;

  typedef logic signed [MFCC_DATA_WIDTH-1:0] mfcc_data_t;
  typedef logic signed [DELTA_ACC_WIDTH-1:0] delta_acc_t;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_CAPTURE,
    DS_COMPUTE,
    DS_DRAIN
  } delta_state_e;

  // round(65536 / (2 * sum_{n=1..N} n^2)); 6554 for N = 2
  function automatic int delta_recip(input int n);
    int den;
    den = 0;
    for (int i = 1; i <= n; i++) den += 2 * i * i;
    return (65536 + den / 2) / den;
  endfunction
endpackage

// File: rtl/mfcc_delta_if.sv
// Frame-in / coefficient-stream-out bundle of the delta stage.
// master drives frames and observes the stream; slave is the delta block.
interface mfcc_delta_if #(
  parameter int NUM_COEFFICIENTS = 13
);
  import mfcc_pkg::*;

  localparam int PTR_W = (NUM_COEFFICIENTS > 1) ? $clog2(NUM_COEFFICIENTS) : 1;

  logic             frame_valid_i;
  mfcc_data_t       coeff_i [0:NUM_COEFFICIENTS-1];
  logic             clear_i;
  logic             out_valid_o;
  logic [PTR_W-1:0] out_ptr_o;
  mfcc_data_t       ceps_o;
  mfcc_data_t       delta_o;
  logic             frame_done_o;
  logic             busy_o;
  logic             dropped_o;

  modport master (
    output frame_valid_i, coeff_i, clear_i,
    input  out_valid_o, out_ptr_o, ceps_o, delta_o, frame_done_o, busy_o, dropped_o
  );

  modport slave (
    input  frame_valid_i, coeff_i, clear_i,
    output out_valid_o, out_ptr_o, ceps_o, delta_o, frame_done_o, busy_o, dropped_o
  );
endinterface

// File: rtl/mfcc_delta_hist.sv
// Frame-history ring: one slot per frame, write-slot/fill tracking, and a
// read port returning coefficient rd_idx of every slot, newest (tap 0) to oldest.
module mfcc_delta_hist
  import mfcc_pkg::*;
#(
  parameter int NUM_COEFFICIENTS = 13,
  parameter int HIST_DEPTH       = 5,
  parameter int SLOT_W           = 3,
  parameter int PTR_W            = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clear,
  input  mfcc_data_t        wr_dat [0:NUM_COEFFICIENTS-1],
  input  logic [SLOT_W-1:0] base_slot,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [SLOT_W-1:0] newest_slot_o,
  output logic              full_o,
  output mfcc_data_t        taps_o [0:HIST_DEPTH-1]
);
  localparam int                FILL_W    = $clog2(HIST_DEPTH + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(HIST_DEPTH - 1);
  localparam logic [FILL_W-1:0] FULL      = FILL_W'(HIST_DEPTH);

  mfcc_data_t        ring_q [0:HIST_DEPTH-1][0:NUM_COEFFICIENTS-1];
  mfcc_data_t        ring_d [0:HIST_DEPTH-1][0:NUM_COEFFICIENTS-1];
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d, slot_eff;
  logic [FILL_W-1:0] fill_q, fill_d, fill_eff;
  logic [SLOT_W-1:0] tap_slot [0:HIST_DEPTH-1];

  // A clear in the same cycle as a write lands the frame in slot 0 with fill 1.
  always_comb begin
    slot_eff  = clear ? '0 : wr_slot_q;
    fill_eff  = clear ? '0 : fill_q;
    wr_slot_d = slot_eff;
    fill_d    = fill_eff;
    ring_d    = ring_q;
    if (wr_en) begin
      ring_d[slot_eff] = wr_dat;
      wr_slot_d        = (slot_eff == LAST_SLOT) ? '0 : slot_eff + SLOT_W'(1);
      fill_d           = (fill_eff == FULL) ? FULL : fill_eff + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_slot_q <= '0;
      fill_q    <= '0;
    end else begin
      wr_slot_q <= wr_slot_d;
      fill_q    <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    ring_q <= ring_d;
  end

  assign newest_slot_o = (wr_slot_q == '0) ? LAST_SLOT : wr_slot_q - SLOT_W'(1);
  assign full_o        = (fill_q == FULL);

  always_comb begin
    for (int j = 0; j < HIST_DEPTH; j++) begin
      tap_slot[j] = (base_slot >= SLOT_W'(j)) ? base_slot - SLOT_W'(j)
                                              : base_slot + SLOT_W'(HIST_DEPTH - j);
      taps_o[j]   = ring_q[tap_slot[j]][rd_idx];
    end
  end
endmodule

// File: rtl/mfcc_delta.sv
// First-order delta over a 2*DELTA_N+1 frame window; one coefficient per cycle,
// first output 4 cycles after frame_valid_i; frames arriving while busy are dropped.
module mfcc_delta
  import mfcc_pkg::*;
#(
  parameter int NUM_COEFFICIENTS = 13,
  parameter int DELTA_N          = 2
) (
  input logic         clk,
  input logic         rst_n,
  mfcc_delta_if.slave bus
);
  localparam int               HIST_DEPTH = 2 * DELTA_N + 1;
  localparam int               SLOT_W     = $clog2(HIST_DEPTH);
  localparam int               PTR_W      = (NUM_COEFFICIENTS > 1) ? $clog2(NUM_COEFFICIENTS) : 1;
  localparam logic [PTR_W-1:0] LAST_K     = PTR_W'(NUM_COEFFICIENTS - 1);
  localparam logic [15:0]      RECIP      = 16'(delta_recip(DELTA_N));
  localparam int               PROD_W     = DELTA_ACC_WIDTH + 17;

  delta_state_e      state_q, state_d;
  logic              busy, accept, issue, capture, dropped;
  logic [PTR_W-1:0]  k_q, k_d;
  logic [SLOT_W-1:0] base_q, base_d, newest_slot;
  logic              drain_q, drain_d, frame_done_q, frame_done_d;
  logic              hist_full;
  mfcc_data_t        taps [0:HIST_DEPTH-1];

  logic              s1_vld_q, s1_vld_d;
  logic [PTR_W-1:0]  s1_ptr_q, s1_ptr_d;
  mfcc_data_t        s1_ceps_q, s1_ceps_d;
  delta_acc_t        s1_acc_q, s1_acc_d;
  logic signed [PROD_W-1:0] prod, rnd;

  logic              out_vld_q, out_vld_d;
  logic [PTR_W-1:0]  out_ptr_q, out_ptr_d;
  mfcc_data_t        ceps_q, ceps_d, delta_q, delta_d;

  // sum n*(newer - older) with the per-tap weight built from shifts and adds
  function automatic delta_acc_t regress(input mfcc_data_t t [0:HIST_DEPTH-1]);
    delta_acc_t acc;
    delta_acc_t diff;
    acc = '0;
    for (int n = 1; n <= DELTA_N; n++) begin
      diff = delta_acc_t'(t[DELTA_N-n]) - delta_acc_t'(t[DELTA_N+n]);
      if (n[0]) acc += diff;
      if (n[1]) acc += diff <<< 1;
    end
    return acc;
  endfunction

  mfcc_delta_hist #(
    .NUM_COEFFICIENTS(NUM_COEFFICIENTS),
    .HIST_DEPTH      (HIST_DEPTH),
    .SLOT_W          (SLOT_W),
    .PTR_W           (PTR_W)
  ) u_hist (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (accept),
    .clear        (bus.clear_i),
    .wr_dat       (bus.coeff_i),
    .base_slot    (base_q),
    .rd_idx       (k_q),
    .newest_slot_o(newest_slot),
    .full_o       (hist_full),
    .taps_o       (taps)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE:    if (bus.frame_valid_i) state_d = DS_CAPTURE;
      DS_CAPTURE: state_d = hist_full ? DS_COMPUTE : DS_IDLE;
      DS_COMPUTE: if (k_q == LAST_K) state_d = DS_DRAIN;
      DS_DRAIN:   if (drain_q) state_d = DS_IDLE;
      default:    state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != DS_IDLE);
    accept  = (state_q == DS_IDLE) && bus.frame_valid_i;
    dropped = busy && bus.frame_valid_i;
    capture = (state_q == DS_CAPTURE);
    issue   = (state_q == DS_COMPUTE);
  end

  // The window base is latched at capture so a clear mid-frame cannot shift the taps.
  always_comb begin
    k_d          = issue ? k_q + PTR_W'(1) : '0;
    base_d       = capture ? newest_slot : base_q;
    drain_d      = (state_q == DS_DRAIN) && !drain_q;
    frame_done_d = (state_q == DS_DRAIN) && drain_q;

    s1_vld_d  = issue;
    s1_ptr_d  = s1_ptr_q;
    s1_ceps_d = s1_ceps_q;
    s1_acc_d  = s1_acc_q;
    if (issue) begin
      s1_ptr_d  = k_q;
      s1_ceps_d = taps[DELTA_N];
      s1_acc_d  = regress(taps);
    end

    prod      = PROD_W'(s1_acc_q) * PROD_W'($signed({1'b0, RECIP}));
    rnd       = (prod + PROD_W'(32768)) >>> 16;
    out_vld_d = s1_vld_q;
    out_ptr_d = out_ptr_q;
    ceps_d    = ceps_q;
    delta_d   = delta_q;
    if (s1_vld_q) begin
      out_ptr_d = s1_ptr_q;
      ceps_d    = s1_ceps_q;
      delta_d   = rnd[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q          <= '0;
      base_q       <= '0;
      drain_q      <= 1'b0;
      frame_done_q <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_ptr_q     <= '0;
      s1_ceps_q    <= '0;
      s1_acc_q     <= '0;
      out_vld_q    <= 1'b0;
      out_ptr_q    <= '0;
      ceps_q       <= '0;
      delta_q      <= '0;
    end else begin
      k_q          <= k_d;
      base_q       <= base_d;
      drain_q      <= drain_d;
      frame_done_q <= frame_done_d;
      s1_vld_q     <= s1_vld_d;
      s1_ptr_q     <= s1_ptr_d;
      s1_ceps_q    <= s1_ceps_d;
      s1_acc_q     <= s1_acc_d;
      out_vld_q    <= out_vld_d;
      out_ptr_q    <= out_ptr_d;
      ceps_q       <= ceps_d;
      delta_q      <= delta_d;
    end
  end

  rounded_delta_fits_16b: assert property (@(posedge clk) disable iff (!rst_n)
    s1_vld_q |-> (rnd[PROD_W-1:15] == {(PROD_W-15){rnd[15]}}));

  assign bus.out_valid_o  = out_vld_q;
  assign bus.out_ptr_o    = out_ptr_q;
  assign bus.ceps_o       = ceps_q;
  assign bus.delta_o      = delta_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.busy_o       = busy;
  assign bus.dropped_o    = dropped;
endmodule

// File: tb/tb_mfcc_delta.sv
// Directed and randomised frames for mfcc_delta, scored against a sliding-window
// delta model that predicts values, output cycles, drops and frame_done timing.
module tb_mfcc_delta;
  import mfcc_pkg::*;

  localparam int     NC    = 13;
  localparam int     DN    = 2;
  localparam int     HD    = 2 * DN + 1;
  localparam longint RECIP = 6554;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mfcc_delta_if #(.NUM_COEFFICIENTS(NC)) bus ();

  mfcc_delta #(.NUM_COEFFICIENTS(NC), .DELTA_N(DN)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int cyc;
    int ptr;
    int ceps;
    int dlt;
  } exp_t;

  exp_t       expq[$];
  int         doneq[$];
  int         hist [0:HD-1][0:NC-1];
  int         hcount = 0;
  int         free_at = 0;
  mfcc_data_t fbuf [0:NC-1];
  int         n_checks = 0;
  int         n_pass = 0;
  exp_t       mon_e;
  int         mon_d;

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window model: hist[HD-1] is the newest frame, hist[DN] the centre.
  task automatic model_accept(input int c0, input bit clr);
    longint s;
    exp_t   e;
    if (clr) hcount = 0;
    for (int i = 0; i < HD - 1; i++)
      for (int k = 0; k < NC; k++) hist[i][k] = hist[i+1][k];
    for (int k = 0; k < NC; k++) hist[HD-1][k] = int'(fbuf[k]);
    if (hcount < HD) hcount++;
    if (hcount == HD) begin
      for (int k = 0; k < NC; k++) begin
        s = 0;
        for (int n = 1; n <= DN; n++) s += n * (hist[DN+n][k] - hist[DN-n][k]);
        e.cyc  = c0 + 4 + k;
        e.ptr  = k;
        e.ceps = hist[DN][k];
        e.dlt  = int'((s * RECIP + 32768) >>> 16);
        expq.push_back(e);
      end
      doneq.push_back(c0 + NC + 4);
      free_at = c0 + NC + 4;
    end else begin
      free_at = c0 + 2;
    end
  endtask

  task automatic send_frame(input bit clr_req);
    bit acc;
    acc = (cyc >= free_at);
    bus.frame_valid_i = 1'b1;
    bus.clear_i       = clr_req && acc;
    for (int k = 0; k < NC; k++) bus.coeff_i[k] = fbuf[k];
    if (acc) model_accept(cyc, clr_req);
    @(negedge clk);
    if (acc) check("dropped_when_idle", bus.dropped_o, 0);
    else     check("dropped_when_busy", bus.dropped_o, 1);
    tick();
    bus.frame_valid_i = 1'b0;
    bus.clear_i       = 1'b0;
  endtask

  task automatic clear_pulse();
    bus.clear_i = 1'b1;
    hcount      = 0;
    tick();
    bus.clear_i = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc < free_at) tick();
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NC; k++) fbuf[k] = mfcc_data_t'($urandom);
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < NC; k++) fbuf[k] = mfcc_data_t'(v);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid_o) begin
        if (expq.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          mon_e = expq.pop_front();
          check("out_cycle", cyc, mon_e.cyc);
          check("out_ptr", bus.out_ptr_o, mon_e.ptr);
          check("ceps", bus.ceps_o, mon_e.ceps);
          check("delta", bus.delta_o, mon_e.dlt);
        end
      end
      if (bus.frame_done_o) begin
        if (doneq.size() == 0) begin
          check("spurious_frame_done", 1, 0);
        end else begin
          mon_d = doneq.pop_front();
          check("frame_done_cycle", cyc, mon_d);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ext [0:HD-1];
    int c0;

    rst_n             = 1'b0;
    bus.frame_valid_i = 1'b0;
    bus.clear_i       = 1'b0;
    fill_const(0);
    for (int k = 0; k < NC; k++) bus.coeff_i[k] = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_out_ptr", bus.out_ptr_o, 0);
    check("rst_ceps", bus.ceps_o, 0);
    check("rst_delta", bus.delta_o, 0);
    check("rst_frame_done", bus.frame_done_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_dropped", bus.dropped_o, 0);
    rst_n = 1'b1;
    tick();
    free_at = cyc;

    // ramp: every delta is 100, centre frames 2..4
    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < NC; k++) fbuf[k] = mfcc_data_t'(100 * t + k);
      wait_free();
      send_frame(1'b0);
    end
    wait_free();
    repeat (3) tick();
    check("ramp_delta_hold", bus.delta_o, 100);
    check("ramp_ceps_hold", bus.ceps_o, 412);
    check("ramp_ptr_hold", bus.out_ptr_o, NC - 1);

    // constant frames after a coincident clear
    for (int i = 0; i < HD; i++) begin
      fill_const(1234);
      wait_free();
      send_frame(i == 0);
    end
    wait_free();
    check("const_delta", bus.delta_o, 0);

    // extremes, then the swapped window
    ext = '{-32768, -32768, 0, 32767, 32767};
    for (int i = 0; i < HD; i++) begin
      fill_const(ext[i]);
      wait_free();
      send_frame(i == 0);
    end
    wait_free();
    check("extreme_pos_delta", bus.delta_o, 19662);
    for (int i = 0; i < HD; i++) begin
      fill_const(ext[HD-1-i]);
      wait_free();
      send_frame(i == 0);
    end
    wait_free();
    check("extreme_neg_delta", bus.delta_o, -19662);

    // overrun at COMPUTE cycle 5
    rand_frame();
    c0 = cyc;
    send_frame(1'b0);
    while (cyc < c0 + 7) tick();
    check("busy_in_compute", bus.busy_o, 1);
    rand_frame();
    send_frame(1'b0);
    wait_free();
    rand_frame();
    send_frame(1'b0);

    // clear after six frames: four silent frames, the fifth resumes output
    for (int i = 0; i < 6; i++) begin
      rand_frame();
      wait_free();
      send_frame(1'b0);
    end
    wait_free();
    clear_pulse();
    for (int i = 0; i < HD; i++) begin
      rand_frame();
      wait_free();
      send_frame(1'b0);
    end
    wait_free();

    // random traffic: gaps, overruns, clears
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        clear_pulse();
      end else begin
        rand_frame();
        send_frame($urandom_range(0, 7) == 0);
      end
      repeat ($urandom_range(0, 20)) tick();
    end
    wait_free();

    // reset at COMPUTE cycle 8
    while (hcount < HD) begin
      rand_frame();
      wait_free();
      send_frame(1'b0);
    end
    wait_free();
    rand_frame();
    c0 = cyc;
    send_frame(1'b0);
    while (cyc < c0 + 10) tick();
    rst_n  = 1'b0;
    hcount = 0;
    expq.delete();
    doneq.delete();
    tick();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid_o, 0);
    check("midrst_frame_done", bus.frame_done_o, 0);
    check("midrst_busy", bus.busy_o, 0);
    rst_n = 1'b1;
    tick();
    free_at = cyc;
    for (int i = 0; i < HD; i++) begin
      rand_frame();
      wait_free();
      send_frame(1'b0);
    end
    wait_free();

    repeat (30) tick();
    check("pending_outputs", expq.size(), 0);
    check("pending_frame_done", doneq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
